// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared types and constants for the RGB565 LCD timing controller.
//   rgb565_t       : packed {R[4:0], G[5:0], B[4:0]} pixel
//   ctrl_state_t   : controller run state (IDLE / RUN / DRAIN)
//   DEF_*          : default 800x480 panel timing and underflow fill colour
//   BAR_*          : colour-bar palette used by the optional pattern generator
//   bar_color()    : maps a 3-bit band index to its colour-bar value
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ctrl_state_t;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 48;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 32;

  localparam rgb565_t DEF_FILL_COLOR = 16'h001F;

  localparam rgb565_t BAR_WHITE   = 16'hFFFF;
  localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
  localparam rgb565_t BAR_CYAN    = 16'h07FF;
  localparam rgb565_t BAR_GREEN   = 16'h07E0;
  localparam rgb565_t BAR_MAGENTA = 16'hF81F;
  localparam rgb565_t BAR_RED     = 16'hF800;
  localparam rgb565_t BAR_BLUE    = 16'h001F;
  localparam rgb565_t BAR_BLACK   = 16'h0000;

  // Bands run left to right in the classic SMPTE-like order.
  function automatic rgb565_t bar_color(input logic [2:0] band);
    rgb565_t c;
    case (band)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// ---------------------------------------------------------------------------
// lcd_pattern_gen
// Combinational 8-band colour-bar source, only built with LCD_TEST_PATTERN_EN.
//   h_cnt  in  HW  horizontal pixel position (meaningful while h_cnt < H_ACTIVE)
//   pixel  out 16  colour-bar value for that column; registered by the parent
// ---------------------------------------------------------------------------
`ifdef LCD_TEST_PATTERN_EN
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int HW       = 10
) (
  input  logic [HW-1:0] h_cnt,
  output rgb565_t       pixel
);

  localparam int SW = HW + 3;

  logic [SW-1:0] scaled;
  logic [SW-1:0] band_full;
  logic [2:0]    band;

  // band = h_cnt*8/H_ACTIVE; clamped so blanking columns cannot alias
  // back onto a visible band.
  always_comb begin
    scaled    = {h_cnt, 3'b000};
    band_full = scaled / SW'(H_ACTIVE);
    band      = (band_full > SW'(7)) ? 3'd7 : band_full[2:0];
    pixel     = bar_color(band);
  end

endmodule
`endif

// File: rtl/lcd_timing_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_timing_ctrl
// HSYNC/VSYNC/DE timing generator and pixel scheduler for an RGB565 LCD bus.
// Pulls one pixel per active clock from a first-word-fall-through stream and
// substitutes FILL_COLOR when the stream is empty (the raster never stalls).
// Optional build macro: LCD_TEST_PATTERN_EN adds pattern_sel_i and an
// internal colour-bar source.
//
// Ports
//   clk_i          in   1   pixel clock (same net as LCD_CLK)
//   rst_i          in   1   asynchronous active-high reset
//   en_i           in   1   run request (level); frames always complete
//   pix_data_i     in   16  RGB565 stream word
//   pix_valid_i    in   1   stream word valid
//   pix_ready_o    out  1   stream word consumed this cycle when valid
//   pattern_sel_i  in   1   (LCD_TEST_PATTERN_EN only) select colour bars
//   clr_i          in   1   clears underflow_o
//   LCD_R/G/B      out  5/6/5 registered pixel outputs
//   LCD_DE         out  1   registered data enable, active-high
//   LCD_HSYNC/VSYNC out 1   registered syncs, active-low
//   sof_o          out  1   registered pulse with first DE of each frame
//   underflow_o    out  1   sticky starved-pixel flag
// ---------------------------------------------------------------------------
module lcd_timing_ctrl
  import lcd_pkg::*;
#(
  parameter int      H_ACTIVE   = DEF_H_ACTIVE,
  parameter int      H_FP       = DEF_H_FP,
  parameter int      H_SYNC     = DEF_H_SYNC,
  parameter int      H_BP       = DEF_H_BP,
  parameter int      V_ACTIVE   = DEF_V_ACTIVE,
  parameter int      V_FP       = DEF_V_FP,
  parameter int      V_SYNC     = DEF_V_SYNC,
  parameter int      V_BP       = DEF_V_BP,
  parameter rgb565_t FILL_COLOR = DEF_FILL_COLOR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] pix_data_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
`ifdef LCD_TEST_PATTERN_EN
  input  logic        pattern_sel_i,
`endif
  input  logic        clr_i,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic        LCD_DE,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic        sof_o,
  output logic        underflow_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  ctrl_state_t   state, state_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          running;
  logic          frame_end;
  logic          active;
  logic          hsync_zone;
  logic          vsync_zone;
  logic          pattern_on;
  logic          starve;
  rgb565_t       pix_out;
  rgb565_t       rgb_q;

`ifdef LCD_TEST_PATTERN_EN
  rgb565_t bar_pix;

  lcd_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .HW       (HW)
  ) u_pattern (
    .h_cnt (h_cnt),
    .pixel (bar_pix)
  );

  assign pattern_on = pattern_sel_i;
`else
  assign pattern_on = 1'b0;
`endif

  // Raster decode from the counters. Counters sit at (0,0) in IDLE, so the
  // running qualifier is what keeps DE and the syncs quiet there.
  always_comb begin
    running     = (state != ST_IDLE);
    frame_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    active      = running && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hsync_zone  = running && (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    vsync_zone  = running && (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    pix_ready_o = active && !pattern_on;
    starve      = active && !pattern_on && !pix_valid_i;
  end

  // Pixel source selection; the stream word is taken as-is when valid,
  // otherwise the fill colour keeps the panel timing intact.
  always_comb begin
    pix_out = pix_valid_i ? rgb565_t'(pix_data_i) : FILL_COLOR;
`ifdef LCD_TEST_PATTERN_EN
    if (pattern_on) begin
      pix_out = bar_pix;
    end
`endif
  end

  // Run control. Dropping en_i only takes effect at a frame boundary; at
  // that boundary en_i alone decides whether the next frame follows.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en_i) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_nxt = frame_end ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (frame_end) begin
          state_nxt = en_i ? ST_RUN : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Raster counters: held at zero while idle so the first running cycle
  // is always (0,0).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Pin registers: everything lands one clock after its counter cycle so
  // RGB, DE and syncs stay aligned at the panel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rgb_q       <= '0;
      LCD_DE      <= 1'b0;
      LCD_HSYNC   <= 1'b1;
      LCD_VSYNC   <= 1'b1;
      sof_o       <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      rgb_q     <= active ? pix_out : '0;
      LCD_DE    <= active;
      LCD_HSYNC <= !hsync_zone;
      LCD_VSYNC <= !vsync_zone;
      sof_o     <= active && (h_cnt == '0) && (v_cnt == '0);
      if (starve) begin
        underflow_o <= 1'b1;
      end else if (clr_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

  assign LCD_R = rgb_q[15:11];
  assign LCD_G = rgb_q[10:5];
  assign LCD_B = rgb_q[4:0];

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_timing_ctrl
// Directed bench for lcd_timing_ctrl on a reduced 8x4 raster
// (H 8/2/2/2, V 4/1/1/1 -> 14 clocks per line, 98 clocks per frame).
// A frame-position model predicts every registered output each cycle;
// literal expectations pin pixel order, fill, drain and reset behaviour.
// ---------------------------------------------------------------------------
module tb_lcd_timing_ctrl;

  localparam int H_ACT  = 8;
  localparam int H_FP   = 2;
  localparam int H_SYN  = 2;
  localparam int H_BP   = 2;
  localparam int V_ACT  = 4;
  localparam int V_FP   = 1;
  localparam int V_SYN  = 1;
  localparam int V_BP   = 1;
  localparam int H_TOT  = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYN + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam logic [15:0] FILL = 16'h001F;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] pix_data_i = '0;
  logic        pix_valid_i = 1'b0;
  logic        pix_ready_o;
  logic        pattern_sel = 1'b0;
  logic        clr_i = 1'b0;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic        LCD_DE;
  logic        LCD_HSYNC;
  logic        LCD_VSYNC;
  logic        sof_o;
  logic        underflow_o;

  int checks = 0;
  int passes = 0;

  // Stream source state: word is held until the DUT takes it.
  logic [15:0] src_word = '0;
  bit          take_last = 1'b0;

  // Per-frame capture, indexed by sof count since time zero.
  int          cyc = 0;
  int          sof_total = 0;
  int          sof_cyc [8];
  int          de_cnt [8];
  logic [15:0] pix_log [8][32];

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  always #5 clk = ~clk;

  lcd_timing_ctrl #(
    .H_ACTIVE   (H_ACT),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYN),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACT),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYN),
    .V_BP       (V_BP),
    .FILL_COLOR (FILL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .pix_data_i    (pix_data_i),
    .pix_valid_i   (pix_valid_i),
    .pix_ready_o   (pix_ready_o),
`ifdef LCD_TEST_PATTERN_EN
    .pattern_sel_i (pattern_sel),
`endif
    .clr_i         (clr_i),
    .LCD_R         (LCD_R),
    .LCD_G         (LCD_G),
    .LCD_B         (LCD_B),
    .LCD_DE        (LCD_DE),
    .LCD_HSYNC     (LCD_HSYNC),
    .LCD_VSYNC     (LCD_VSYNC),
    .sof_o         (sof_o),
    .underflow_o   (underflow_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // One clock of stimulus, driven on the falling edge. The stream advances
  // past a word only after the DUT took it on the previous rising edge.
  task automatic applyStimulus(input logic rst, input logic en,
                               input logic valid, input logic clr);
    @(negedge clk);
    if (take_last) src_word = src_word + 16'd1;
    rst_i       = rst;
    en_i        = en;
    pix_valid_i = valid;
    clr_i       = clr;
    pix_data_i  = src_word;
    #1;
    take_last = pix_valid_i && pix_ready_o;
  endtask

  // Frame-position model: m_pos is the clock index within the frame for
  // the counter cycle that ends at this rising edge.
  initial begin : model_check
    bit          m_run;
    int          m_pos;
    bit          m_uf;
    int          h, v, idx;
    bit          act;
    logic [15:0] e_rgb;
    bit          e_de, e_hs, e_vs, e_sof, e_ready;
    m_run = 0; m_pos = 0; m_uf = 0;
    forever begin
      @(posedge clk);
      if (rst_i) begin
        m_run = 0; m_pos = 0; m_uf = 0;
        e_rgb = '0; e_de = 0; e_hs = 1; e_vs = 1; e_sof = 0;
      end else begin
        h     = m_pos % H_TOT;
        v     = m_pos / H_TOT;
        act   = m_run && (h < H_ACT) && (v < V_ACT);
        e_de  = act;
        e_hs  = !(m_run && h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYN);
        e_vs  = !(m_run && v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYN);
        e_sof = act && (m_pos == 0);
        if (!act)             e_rgb = '0;
        else if (pattern_sel) e_rgb = bars[h * 8 / H_ACT];
        else                  e_rgb = pix_valid_i ? pix_data_i : FILL;
        if (act && !pattern_sel && !pix_valid_i) m_uf = 1;
        else if (clr_i)                          m_uf = 0;
        if (m_run) begin
          if (m_pos == FRAME - 1) begin
            m_pos = 0;
            if (!en_i) m_run = 0;
          end else begin
            m_pos++;
          end
        end else if (en_i) begin
          m_run = 1;
          m_pos = 0;
        end
      end
      #1;
      e_ready = m_run && !pattern_sel && ((m_pos % H_TOT) < H_ACT) && ((m_pos / H_TOT) < V_ACT);
      cyc++;
      checkOutput("de",        32'(LCD_DE),               32'(e_de));
      checkOutput("hsync",     32'(LCD_HSYNC),            32'(e_hs));
      checkOutput("vsync",     32'(LCD_VSYNC),            32'(e_vs));
      checkOutput("rgb",       32'({LCD_R, LCD_G, LCD_B}), 32'(e_rgb));
      checkOutput("sof",       32'(sof_o),                32'(e_sof));
      checkOutput("underflow", 32'(underflow_o),          32'(m_uf));
      checkOutput("ready",     32'(pix_ready_o),          32'(e_ready));
      if (sof_o) begin
        if (sof_total < 8) sof_cyc[sof_total] = cyc;
        sof_total++;
      end
      if (LCD_DE && sof_total >= 1 && sof_total <= 8) begin
        idx = sof_total - 1;
        if (de_cnt[idx] < 32) pix_log[idx][de_cnt[idx]] = {LCD_R, LCD_G, LCD_B};
        de_cnt[idx]++;
      end
    end
  end

  // Timeline (step s drives the counter cycle that ends at the s-th edge):
  //   frame0 steps 1..98, frame1 99..196 (pixel 3 starved at 102),
  //   frame2 197..294 with en low from 211 -> idle, restart at 300,
  //   frame3 301..398 with en low 321..379 then back high -> frame4 at 399,
  //   reset at 432 (h=5, v=2 of frame4), frame5 from 435.
  initial begin : stimulus
    logic r, e, vld, c;
    for (int i = 0; i < 8; i++) begin
      de_cnt[i]  = 0;
      sof_cyc[i] = 0;
    end
    #1 rst_i = 1'b1;
    #2;
    checkOutput("reset_de",    32'(LCD_DE),                32'd0);
    checkOutput("reset_hsync", 32'(LCD_HSYNC),             32'd1);
    checkOutput("reset_vsync", 32'(LCD_VSYNC),             32'd1);
    checkOutput("reset_rgb",   32'({LCD_R, LCD_G, LCD_B}), 32'd0);
    checkOutput("reset_sof",   32'(sof_o),                 32'd0);
    checkOutput("reset_uf",    32'(underflow_o),           32'd0);
    checkOutput("reset_ready", 32'(pix_ready_o),           32'd0);

    for (int s = 0; s < 640; s++) begin
      r   = (s >= 432 && s < 434);
      e   = !((s >= 211 && s < 300) || (s >= 321 && s < 380));
      vld = !(s == 102 || s == 401);
      c   = (s >= 150 && s < 152) || (s == 401);
`ifdef LCD_TEST_PATTERN_EN
      pattern_sel = (s >= 520);
`endif
      applyStimulus(r, e, vld, c);

      if (s == 130) checkOutput("uf_sticky",  32'(underflow_o), 32'd1);
      if (s == 153) checkOutput("uf_cleared", 32'(underflow_o), 32'd0);
      if (s == 200) begin
        checkOutput("frame0_de_count", 32'(de_cnt[0]), 32'd32);
        checkOutput("sof_period", 32'(sof_cyc[1] - sof_cyc[0]), 32'd98);
        for (int k = 0; k < 32; k++) begin
          checkOutput($sformatf("frame0_pix%0d", k), 32'(pix_log[0][k]), 32'(k));
        end
        checkOutput("frame1_pix3_fill", 32'(pix_log[1][3]),  32'h001F);
        checkOutput("frame1_pix4_held", 32'(pix_log[1][4]),  32'd35);
        checkOutput("frame1_pix31",     32'(pix_log[1][31]), 32'd62);
      end
      if (s == 297) begin
        checkOutput("drain_de_count", 32'(de_cnt[2]),    32'd32);
        checkOutput("idle_sof_total", 32'(sof_total),    32'd3);
        checkOutput("idle_de",        32'(LCD_DE),       32'd0);
        checkOutput("idle_hsync",     32'(LCD_HSYNC),    32'd1);
        checkOutput("idle_vsync",     32'(LCD_VSYNC),    32'd1);
        checkOutput("idle_ready",     32'(pix_ready_o),  32'd0);
      end
      if (s == 410) checkOutput("uf_set_wins", 32'(underflow_o), 32'd1);
      if (s == 420) checkOutput("seamless_period", 32'(sof_cyc[4] - sof_cyc[3]), 32'd98);
      if (s == 432) begin
        checkOutput("midrst_de",    32'(LCD_DE),                32'd0);
        checkOutput("midrst_hsync", 32'(LCD_HSYNC),             32'd1);
        checkOutput("midrst_vsync", 32'(LCD_VSYNC),             32'd1);
        checkOutput("midrst_rgb",   32'({LCD_R, LCD_G, LCD_B}), 32'd0);
        checkOutput("midrst_sof",   32'(sof_o),                 32'd0);
        checkOutput("midrst_uf",    32'(underflow_o),           32'd0);
        checkOutput("midrst_ready", 32'(pix_ready_o),           32'd0);
      end
      if (s == 540) checkOutput("restart_de_count", 32'(de_cnt[5]), 32'd32);
`ifdef LCD_TEST_PATTERN_EN
      if (s == 639) begin
        checkOutput("bar_pix0", 32'(pix_log[6][0]), 32'hFFFF);
        checkOutput("bar_pix7", 32'(pix_log[6][7]), 32'h0000);
      end
`endif
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
